// File: rtl/falafel_mem_arbiter_pkg.sv
// Arbiter-local types: FSM encoding and requester index sizing.
package falafel_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index so the route FIFO has width.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/falafel_pkg.sv
// Shared falafel types: datapath width and the memory request record.
package falafel_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              is_write;
    logic              is_cas;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] cas_exp;
  } mem_req_t;

endpackage

// File: rtl/falafel_mem_arbiter_if.sv
// External falafel memory port: one request channel, one in-order response channel.
interface falafel_mem_arbiter_if;
  import falafel_pkg::*;

  logic              mem_req_val;
  logic              mem_req_rdy;
  logic              mem_req_is_write;
  logic              mem_req_is_cas;
  logic [DATA_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [DATA_W-1:0] mem_req_cas_exp;
  logic              mem_rsp_val;
  logic              mem_rsp_rdy;
  logic [DATA_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_val, mem_req_is_write, mem_req_is_cas,
           mem_req_addr, mem_req_data, mem_req_cas_exp, mem_rsp_rdy,
    input  mem_req_rdy, mem_rsp_val, mem_rsp_data
  );

  modport slave (
    input  mem_req_val, mem_req_is_write, mem_req_is_cas,
           mem_req_addr, mem_req_data, mem_req_cas_exp, mem_rsp_rdy,
    output mem_req_rdy, mem_rsp_val, mem_rsp_data
  );

endinterface

// File: rtl/falafel_fifo.sv
// Small synchronous FIFO; head entry is visible on pop_data_o whenever non-empty.
module falafel_fifo #(
  parameter int DATA_W      = 1,
  parameter int NUM_ENTRIES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);

  logic [DATA_W-1:0] store_q [NUM_ENTRIES];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign full_o     = (count_q == (PTR_W+1)'(NUM_ENTRIES));
  assign empty_o    = (count_q == '0);
  assign pop_data_o = store_q[rd_ptr_q];

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/falafel_mem_arbiter.sv
// Round-robin arbiter sharing one falafel memory port; responses are steered
// back through an in-order route FIFO of grant indices.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | search for a winner, grant it if the route FIFO has room
//   ST_ISSUE | slice presents the latched request until memory accepts it
module falafel_mem_arbiter
  import falafel_pkg::*;
  import falafel_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_val_i,
  output logic [NUM_REQ-1:0]    req_rdy_o,
  input  mem_req_t              req_i [NUM_REQ],
  output logic [NUM_REQ-1:0]    rsp_val_o,
  input  logic [NUM_REQ-1:0]    rsp_rdy_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  falafel_mem_arbiter_if.master mem,
  output logic                  err_unexp_rsp_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] route_head;
  logic             win_found;
  logic             grant;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_rdy;
  mem_req_t         slice_q;
  mem_req_t         win_req;

  // Winner search: indices at/after rr_ptr_q first, then the wrapped-around ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_req   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_val_i[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_val_i[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_req = req_i[i];
    end
  end

  // Next-state and grant decode; a full route FIFO blocks grants outright.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    push      = 1'b0;
    req_rdy_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !fifo_full) begin
          grant   = 1'b1;
          state_d = ST_ISSUE;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy_o[i] = (win_idx == IDX_W'(i));
          end
        end
      end
      ST_ISSUE: begin
        if (mem.mem_req_rdy) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request slice and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      slice_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        slice_q   <= win_req;
        gnt_idx_q <= win_idx;
      end
      if (push) begin
        rr_ptr_q <= (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
      end
    end
  end

  assign mem.mem_req_val      = (state_q == ST_ISSUE);
  assign mem.mem_req_is_write = slice_q.is_write;
  assign mem.mem_req_is_cas   = slice_q.is_cas;
  assign mem.mem_req_addr     = slice_q.addr;
  assign mem.mem_req_data     = slice_q.data;
  assign mem.mem_req_cas_exp  = slice_q.cas_exp;

  falafel_fifo #(
    .DATA_W      (IDX_W),
    .NUM_ENTRIES (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (gnt_idx_q),
    .pop_i       (pop),
    .pop_data_o  (route_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Response steering to the requester at the head of the route FIFO.
  always_comb begin
    head_rdy  = 1'b0;
    rsp_val_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (route_head == IDX_W'(i)) begin
        head_rdy     = rsp_rdy_i[i];
        rsp_val_o[i] = mem.mem_rsp_val && !fifo_empty;
      end
    end
  end

  assign mem.mem_rsp_rdy = !fifo_empty && head_rdy;
  assign pop             = mem.mem_rsp_val && mem.mem_rsp_rdy;
  assign rsp_data_o      = mem.mem_rsp_data;

  // Sticky flag for a response with nothing outstanding; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_unexp_rsp_o <= 1'b0;
    end else if (mem.mem_rsp_val && fifo_empty) begin
      err_unexp_rsp_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// Bench for falafel_mem_arbiter: directed scenarios plus a random phase, all
// checked against a transaction-level model of grants and in-order routing.
module tb_falafel_mem_arbiter;
  import falafel_pkg::*;

  localparam int N   = 2;
  localparam int MAX = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      req_val_i;
  logic [N-1:0]      req_rdy_o;
  mem_req_t          req_i [N];
  logic [N-1:0]      rsp_val_o;
  logic [N-1:0]      rsp_rdy_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              err_unexp_rsp_o;

  falafel_mem_arbiter_if mem_if();

  falafel_mem_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_val_i       (req_val_i),
    .req_rdy_o       (req_rdy_o),
    .req_i           (req_i),
    .rsp_val_o       (rsp_val_o),
    .rsp_rdy_i       (rsp_rdy_i),
    .rsp_data_o      (rsp_data_o),
    .mem             (mem_if),
    .err_unexp_rsp_o (err_unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: pending request held for memory, rotating priority
  // pointer, and a queue of owners of outstanding requests.
  bit       m_busy;
  mem_req_t m_held;
  int       m_owner;
  int       m_ptr;
  int       m_route[$];
  bit       m_err;
  int       obs_grants[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  function automatic mem_req_t req_of(input int w);
    mem_req_t r;
    r = '0;
    for (int i = 0; i < N; i++) if (i == w) r = req_i[i];
    return r;
  endfunction

  function automatic int m_winner();
    if (m_busy || m_route.size() >= MAX) return -1;
    for (int k = 0; k < N; k++) begin
      if (bit_of(req_val_i, (m_ptr + k) % N)) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_held  = '0;
    m_owner = 0;
    m_ptr   = 0;
    m_route.delete();
    m_err   = 1'b0;
  endtask

  task automatic model_tick();
    int  w;
    bit  pop;
    pop = mem_if.mem_rsp_val && (m_route.size() > 0) && bit_of(rsp_rdy_i, m_route[0]);
    if (mem_if.mem_rsp_val && m_route.size() == 0) m_err = 1'b1;
    w = m_winner();
    if (m_busy) begin
      if (mem_if.mem_req_rdy) begin
        m_route.push_back(m_owner);
        m_ptr  = (m_owner + 1) % N;
        m_busy = 1'b0;
      end
    end else if (w >= 0) begin
      m_busy  = 1'b1;
      m_owner = w;
      m_held  = req_of(w);
    end
    if (pop) void'(m_route.pop_front());
  endtask

  task automatic check_outputs();
    int           w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    w       = m_winner();
    exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
    exp_rsp = (mem_if.mem_rsp_val && m_route.size() > 0) ? (N'(1) << m_route[0]) : '0;
    chk("req_rdy", req_rdy_o, exp_rdy);
    chk("mem_req_val", mem_if.mem_req_val, m_busy);
    if (m_busy) begin
      chk("mem_req_is_write", mem_if.mem_req_is_write, m_held.is_write);
      chk("mem_req_is_cas", mem_if.mem_req_is_cas, m_held.is_cas);
      chk("mem_req_addr", mem_if.mem_req_addr, m_held.addr);
      chk("mem_req_data", mem_if.mem_req_data, m_held.data);
      chk("mem_req_cas_exp", mem_if.mem_req_cas_exp, m_held.cas_exp);
    end
    chk("rsp_val", rsp_val_o, exp_rsp);
    chk("rsp_data", rsp_data_o, mem_if.mem_rsp_data);
    chk("mem_rsp_rdy", mem_if.mem_rsp_rdy,
        (m_route.size() > 0) && bit_of(rsp_rdy_i, m_route[0]));
    chk("err_unexp", err_unexp_rsp_o, m_err);
  endtask

  // One clock: inputs already applied; check, advance model, wait for edge.
  task automatic cycle();
    #1;
    check_outputs();
    if (req_rdy_o[0]) obs_grants.push_back(0);
    else if (req_rdy_o[1]) obs_grants.push_back(1);
    model_tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_req(input int i);
    mem_req_t r;
    r.is_write = 1'($urandom_range(0, 1));
    r.is_cas   = 1'($urandom_range(0, 1));
    r.addr     = $urandom;
    r.data     = $urandom;
    r.cas_exp  = $urandom;
    req_i[i]   = r;
  endtask

  task automatic clear_inputs();
    req_val_i               = '0;
    rsp_rdy_i               = '0;
    mem_if.mem_req_rdy      = 1'b0;
    mem_if.mem_rsp_val      = 1'b0;
    mem_if.mem_rsp_data     = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    req_val_i          = '0;
    mem_if.mem_req_rdy = 1'b1;
    rsp_rdy_i          = '1;
    for (int k = 0; k < 20 && (m_route.size() > 0 || m_busy); k++) begin
      mem_if.mem_rsp_val  = (m_route.size() > 0);
      mem_if.mem_rsp_data = $urandom;
      cycle();
    end
    chk("drain_done", (m_route.size() == 0 && !m_busy), 1'b1);
    clear_inputs();
  endtask

  initial begin
    req_i[0] = '0;
    req_i[1] = '0;
    clear_inputs();
    model_reset();

    // Reset values
    #2;
    chk("rst_req_rdy", req_rdy_o, 0);
    chk("rst_mem_req_val", mem_if.mem_req_val, 0);
    chk("rst_mem_req_is_write", mem_if.mem_req_is_write, 0);
    chk("rst_mem_req_is_cas", mem_if.mem_req_is_cas, 0);
    chk("rst_mem_req_addr", mem_if.mem_req_addr, 0);
    chk("rst_mem_req_data", mem_if.mem_req_data, 0);
    chk("rst_mem_req_cas_exp", mem_if.mem_req_cas_exp, 0);
    chk("rst_rsp_val", rsp_val_o, 0);
    chk("rst_err", err_unexp_rsp_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single requester read of 0x40, response 0xAB
    rand_req(0);
    req_i[0].is_write = 1'b0;
    req_i[0].is_cas   = 1'b0;
    req_i[0].addr     = 32'h40;
    req_val_i         = 2'b01;
    #1 chk("single_rdy", req_rdy_o, 2'b01);
    cycle();
    req_val_i = '0;
    #1;
    chk("single_mem_val", mem_if.mem_req_val, 1);
    chk("single_mem_addr", mem_if.mem_req_addr, 32'h40);
    mem_if.mem_req_rdy = 1'b1;
    cycle();
    mem_if.mem_req_rdy  = 1'b0;
    mem_if.mem_rsp_val  = 1'b1;
    mem_if.mem_rsp_data = 32'hAB;
    rsp_rdy_i           = 2'b11;
    #1;
    chk("single_rsp_val", rsp_val_o, 2'b01);
    chk("single_rsp_data", rsp_data_o, 32'hAB);
    cycle();
    clear_inputs();
    cycle();

    // Round-robin with both requesters valid, then responses 0x10..0x13
    apply_reset();
    obs_grants.delete();
    req_val_i          = 2'b11;
    mem_if.mem_req_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_req(0);
      rand_req(1);
      cycle();
    end
    req_val_i          = '0;
    mem_if.mem_req_rdy = 1'b0;
    chk("rr_count", obs_grants.size(), 4);
    for (int k = 0; k < 4 && k < obs_grants.size(); k++) chk("rr_order", obs_grants[k], k % 2);
    rsp_rdy_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      mem_if.mem_rsp_val  = 1'b1;
      mem_if.mem_rsp_data = 32'h10 + k;
      #1 chk("rr_rsp_route", rsp_val_o, 2'b01 << (k % 2));
      cycle();
    end
    clear_inputs();
    cycle();

    // Request backpressure: memory stalls five cycles
    rand_req(1);
    req_val_i = 2'b10;
    cycle();
    req_val_i = '0;
    begin
      mem_req_t held;
      held = req_i[1];
      for (int c = 0; c < 5; c++) begin
        req_val_i = 2'($urandom_range(0, 3));
        rand_req(0);
        rand_req(1);
        cycle();
        chk("bp_addr_stable", mem_if.mem_req_addr, held.addr);
        chk("bp_no_rdy", req_rdy_o, 0);
      end
    end
    req_val_i          = '0;
    mem_if.mem_req_rdy = 1'b1;
    cycle();
    drain();

    // FIFO full: four issued, fifth held off until a pop has retired
    apply_reset();
    req_val_i          = 2'b11;
    mem_if.mem_req_rdy = 1'b1;
    for (int c = 0; c < 8; c++) cycle();
    for (int c = 0; c < 2; c++) begin
      #1 chk("full_no_gnt", req_rdy_o, 0);
      cycle();
    end
    mem_if.mem_rsp_val  = 1'b1;
    mem_if.mem_rsp_data = $urandom;
    rsp_rdy_i           = 2'b11;
    #1 chk("full_pop_no_gnt", req_rdy_o, 0);
    cycle();
    mem_if.mem_rsp_val = 1'b0;
    #1 chk("full_gnt_after_pop", req_rdy_o != 0, 1);
    cycle();
    req_val_i = '0;
    cycle();
    chk("full_outstanding", m_route.size(), 4);

    // Response backpressure: head owner not ready
    mem_if.mem_rsp_val  = 1'b1;
    mem_if.mem_rsp_data = $urandom;
    rsp_rdy_i           = '0;
    for (int c = 0; c < 2; c++) begin
      #1 chk("rspbp_no_rdy", mem_if.mem_rsp_rdy, 0);
      cycle();
    end
    chk("rspbp_no_pop", m_route.size(), 4);
    drain();

    // Unexpected response sets a sticky flag
    mem_if.mem_rsp_val = 1'b1;
    #1 chk("unexp_no_rdy", mem_if.mem_rsp_rdy, 0);
    cycle();
    mem_if.mem_rsp_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("unexp_sticky", err_unexp_rsp_o, 1);
    end
    apply_reset();
    #1 chk("unexp_cleared", err_unexp_rsp_o, 0);

    // Reset while a request is being held for memory
    rand_req(0);
    req_val_i = 2'b01;
    cycle();
    req_val_i = '0;
    chk("midrst_busy", mem_if.mem_req_val, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_val_drop", mem_if.mem_req_val, 0);
    model_reset();
    check_outputs();
    @(posedge clk_i);
    #1;
    rst_ni              = 1'b1;
    mem_if.mem_rsp_val  = 1'b1;
    mem_if.mem_rsp_data = $urandom;
    rsp_rdy_i           = 2'b11;
    #1;
    chk("midrst_late_rdy", mem_if.mem_rsp_rdy, 0);
    chk("midrst_late_rsp_val", rsp_val_o, 0);
    cycle();
    clear_inputs();
    cycle();
    chk("midrst_late_err", err_unexp_rsp_o, 1);

    // Random traffic against the model
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_val_i           = 2'($urandom_range(0, 3));
      rand_req(0);
      rand_req(1);
      mem_if.mem_req_rdy  = 1'($urandom_range(0, 1));
      mem_if.mem_rsp_val  = (m_route.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_if.mem_rsp_data = $urandom;
      rsp_rdy_i           = 2'($urandom_range(0, 3));
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
